// File: rtl/imem_program_writer.sv
// imem_program_writer: encodes symbolic instructions into 32-bit words and writes them into the instruction memory, with NOP padding and optional load-use bubbles.
module imem_program_writer #(
  parameter int DEPTH      = 20,
  parameter int AW         = 5,
  parameter int HAZARD_NOP = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [1:0]    in_rs,
  input  logic [1:0]    in_rt,
  input  logic [1:0]    in_rd,
  input  logic [7:0]    in_imm,
  input  logic          finish,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic [AW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);
  localparam logic [AW-1:0] FULL  = AW'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST2 = AW'(DEPTH - 2);
  typedef enum logic [2:0] {IDLE, LOAD, BUBBLE, PAD, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] count_q, count_d, addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, hold_q, hold_d, word;
  logic [1:0] code_q, code_d, ld_rt_q, ld_rt_d, ecode;
  logic err_q, err_d, we_q, we_d, ld_q, ld_d, padp_q, padp_d, done_q;
  logic bad_imm, dep;
  always_comb begin
    case (in_op)
      3'd1:    word = {8'h20, 6'd0, in_rs, 6'd0, in_rt, 6'd0, in_rd};
      3'd2:    word = {8'h10, 6'd0, in_rs, 6'd0, in_rt, 6'd0, in_rd};
      3'd3:    word = {8'h08, 6'd0, in_rs, in_imm, 6'd0, in_rd};
      3'd4:    word = {8'h04, 6'd0, in_rs, in_imm, 6'd0, in_rd};
      3'd5:    word = {8'h40, in_imm, 6'd0, in_rt, 8'd0};
      3'd6:    word = {8'h80, in_imm, 6'd0, in_rt, 8'd0};
      default: word = '0;
    endcase
  end
  assign bad_imm = ((in_op == 3'd3 || in_op == 3'd4) && in_imm > 8'd31) ||
                   ((in_op == 3'd5 || in_op == 3'd6) && in_imm > 8'd7);
  // A consumer reading the register a LOAD just targeted needs one slot of separation.
  assign dep = (HAZARD_NOP != 0) && ld_q &&
               (((in_op >= 3'd1 && in_op <= 3'd4) && in_rs == ld_rt_q) ||
                ((in_op == 3'd1 || in_op == 3'd2) && in_rt == ld_rt_q));
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    ld_d    = ld_q;
    ld_rt_d = ld_rt_q;
    padp_d  = padp_q;
    ecode   = 2'd0;
    if (start) begin
      state_d = LOAD;
      count_d = '0;
      err_d   = 1'b0;
      code_d  = 2'd0;
      ld_d    = 1'b0;
      padp_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (in_valid) begin
            if (in_op == 3'd7) ecode = 2'd1;
            else if (bad_imm) ecode = 2'd2;
            else if (dep ? (count_q > LAST2) : (count_q >= FULL)) ecode = 2'd3;
            else begin
              we_d    = 1'b1;
              addr_d  = count_q;
              count_d = count_q + 1'b1;
              wdata_d = dep ? 32'd0 : word;
              hold_d  = word;
              ld_d    = !dep && in_op == 3'd6;
              ld_rt_d = in_rt;
              state_d = dep ? BUBBLE : LOAD;
            end
          end
          if (finish) begin
            if (state_d == BUBBLE) padp_d = 1'b1;
            else state_d = (count_d == FULL) ? DONE : PAD;
          end
        end
        BUBBLE: begin
          we_d    = 1'b1;
          addr_d  = count_q;
          wdata_d = hold_q;
          count_d = count_q + 1'b1;
          ld_d    = 1'b0;
          padp_d  = 1'b0;
          state_d = padp_q ? ((count_d == FULL) ? DONE : PAD) : LOAD;
        end
        PAD: begin
          we_d    = 1'b1;
          addr_d  = count_q;
          wdata_d = 32'd0;
          count_d = count_q + 1'b1;
          ld_d    = 1'b0;
          state_d = (count_q == LAST) ? DONE : PAD;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
    if (ecode != 2'd0) begin
      err_d  = 1'b1;
      code_d = err_q ? code_q : ecode;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      ld_q    <= 1'b0;
      ld_rt_q <= 2'd0;
      padp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      ld_q    <= ld_d;
      ld_rt_q <= ld_rt_d;
      padp_q  <= padp_d;
      done_q  <= (state_q == DONE) && (state_d == DONE);
    end
  end
  assign in_ready = state_q == LOAD;
  assign busy     = state_q == LOAD || state_q == BUBBLE || state_q == PAD;
  assign done     = done_q;
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign err      = err_q;
  assign err_code = code_q;
endmodule
